// File: rtl/instr_encoder.sv
// Encodes instruction descriptors into 32-bit RV64 words and queues them,
// with a dequeue-time PC, for a decoder's fetch-side inputs.
module instr_encoder #(
    parameter int          DEPTH     = 2,
    parameter logic [63:0] BOOT_ADDR = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] imm_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instruction_o,
    output logic [63:0] pc_o,
    output logic        illegal_o,
    output logic [31:0] issued_o
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [63:0]   pc_q, pc_d;
    logic [31:0]   issued_q, issued_d;
    logic [32:0]   mem_q [DEPTH];

    logic [31:0]   enc_word;
    logic          enc_illegal;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [32:0]   head;

    always_comb begin
        enc_word    = '0;
        enc_illegal = 1'b0;
        case (fmt_i)
            FMT_R: enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            FMT_I: enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            FMT_S: enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            FMT_B: enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                               imm_i[4:1], imm_i[11], opcode_i};
            FMT_U: enc_word = {imm_i[31:12], rd_i, opcode_i};
            FMT_J: enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                               rd_i, opcode_i};
            default: enc_illegal = 1'b1;
        endcase
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = req_valid_i && !full;
    assign pop   = instr_ready_i && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pc_d     = pc_q;
        issued_d = issued_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            pc_d     = pc_q + 64'd4;
            issued_d = issued_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            pc_q     <= BOOT_ADDR;
            issued_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            pc_q     <= pc_d;
            issued_q <= issued_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {enc_illegal, enc_word};
        end
    end

    assign head          = mem_q[rd_ptr_q[AW-1:0]];
    assign req_ready_o   = !full;
    assign instr_valid_o = !empty;
    assign instruction_o = empty ? 32'h0 : head[31:0];
    assign illegal_o     = empty ? 1'b0 : head[32];
    assign pc_o          = pc_q;
    assign issued_o      = issued_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a queue-based
// reference model built from the field-placement rules.
module tb_instr_encoder;

    localparam int          DEPTH = 2;
    localparam logic [63:0] BOOT  = 64'h8000_0000;
    localparam logic [63:0] WBOOT = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [63:0] pc;
    logic        illegal;
    logic [31:0] issued;

    logic        w_req_valid, w_req_ready, w_instr_valid, w_instr_ready, w_illegal;
    logic [31:0] w_instruction, w_issued;
    logic [63:0] w_pc;

    int vectors;
    int miscompares;

    logic [32:0] mq[$];
    logic [63:0] m_pc;
    logic [31:0] m_iss;

    instr_encoder #(.DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .fmt_i(fmt), .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
        .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .imm_i(imm),
        .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
        .instruction_o(instruction), .pc_o(pc), .illegal_o(illegal),
        .issued_o(issued)
    );

    instr_encoder #(.DEPTH(DEPTH), .BOOT_ADDR(WBOOT)) u_wrap (
        .clk(clk), .reset(reset),
        .req_valid_i(w_req_valid), .req_ready_o(w_req_ready),
        .fmt_i(3'd0), .opcode_i(7'h33), .funct3_i(3'd0), .funct7_i(7'd0),
        .rs1_i(5'd1), .rs2_i(5'd2), .rd_i(5'd3), .imm_i(32'd0),
        .instr_valid_o(w_instr_valid), .instr_ready_i(w_instr_ready),
        .instruction_o(w_instruction), .pc_o(w_pc), .illegal_o(w_illegal),
        .issued_o(w_issued)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field placement written as shift-and-mask arithmetic on the immediate.
    function automatic logic [32:0] ref_encode(
        input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
        input logic [6:0] f7, input logic [4:0] a, input logic [4:0] b,
        input logic [4:0] d, input logic [31:0] im);
        logic [31:0] w;
        logic [31:0] base_rs;
        base_rs = (32'(b) << 20) | (32'(a) << 15) | (32'(f3) << 12) | 32'(op);
        case (f)
            3'd0: return {1'b0, (32'(f7) << 25) | base_rs | (32'(d) << 7)};
            3'd1: begin
                w = ((im & 32'hFFF) << 20) | (32'(a) << 15) | (32'(f3) << 12)
                    | (32'(d) << 7) | 32'(op);
                return {1'b0, w};
            end
            3'd2: begin
                w = (((im >> 5) & 32'h7F) << 25) | base_rs | ((im & 32'h1F) << 7);
                return {1'b0, w};
            end
            3'd3: begin
                w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | base_rs
                    | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
                return {1'b0, w};
            end
            3'd4: return {1'b0, (im & 32'hFFFF_F000) | (32'(d) << 7) | 32'(op)};
            3'd5: begin
                w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                    | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                    | (32'(d) << 7) | 32'(op);
                return {1'b0, w};
            end
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    task automatic set_desc(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] a, input logic [4:0] b,
                            input logic [4:0] d, input logic [31:0] im);
        fmt = f; opcode = op; funct3 = f3; funct7 = f7;
        rs1 = a; rs2 = b; rd = d; imm = im;
    endtask

    task automatic rand_desc(input int fmax);
        set_desc(3'($urandom_range(0, fmax)), 7'($urandom), 3'($urandom), 7'($urandom),
                 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
    endtask

    // One rising edge; the model advances from the inputs as seen at that edge.
    task automatic tick();
        bit acc, pp;
        logic [32:0] enc;
        acc = req_valid && (mq.size() < DEPTH);
        pp  = instr_ready && (mq.size() != 0);
        enc = ref_encode(fmt, opcode, funct3, funct7, rs1, rs2, rd, imm);
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_pc  = BOOT;
            m_iss = 0;
        end else begin
            if (pp) begin
                void'(mq.pop_front());
                m_pc  = m_pc + 64'd4;
                m_iss = m_iss + 32'd1;
            end
            if (acc) mq.push_back(enc);
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = 1'b0; instr_ready = 1'b0;
        w_req_valid = 1'b0; w_instr_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors += 6;
        if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        if (pc !== BOOT) begin miscompares++; $display("FAIL reset_pc: got %h expected %h", pc, BOOT); end
        if (issued !== 32'd0) begin miscompares++; $display("FAIL reset_issued: got %h expected 0", issued); end
        if (instruction !== 32'd0) begin miscompares++; $display("FAIL reset_instr: got %h expected 0", instruction); end
        if (illegal !== 1'b0) begin miscompares++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
    endtask

    task automatic test_add();
        set_desc(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, $urandom);
        req_valid = 1'b1; instr_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        vectors += 3;
        if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL add_valid: got %b expected 1", instr_valid); end
        if (instruction !== 32'h002081B3) begin miscompares++; $display("FAIL add_word: got %h expected 002081b3", instruction); end
        if (pc !== 64'h8000_0000) begin miscompares++; $display("FAIL add_pc: got %h expected 80000000", pc); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        vectors += 3;
        if (issued !== 32'd1) begin miscompares++; $display("FAIL add_issued: got %h expected 1", issued); end
        if (pc !== 64'h8000_0004) begin miscompares++; $display("FAIL add_pc_next: got %h expected 80000004", pc); end
        if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL add_drained: got %b expected 0", instr_valid); end
    endtask

    task automatic test_imm_formats();
        logic [31:0] exp_w [4];
        logic [63:0] base;
        exp_w[0] = 32'hFFF00093; exp_w[1] = 32'h0020B423;
        exp_w[2] = 32'hFE208EE3; exp_w[3] = 32'h001000EF;
        base = m_pc;
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set_desc(3'd1, 7'h13, 3'd0, 7'($urandom), 5'd0, 5'($urandom), 5'd1, 32'hFFFF_FFFF);
                1: set_desc(3'd2, 7'h23, 3'd3, 7'($urandom), 5'd1, 5'd2, 5'($urandom), 32'h8);
                2: set_desc(3'd3, 7'h63, 3'd0, 7'($urandom), 5'd1, 5'd2, 5'($urandom), 32'hFFFF_FFFC);
                default: set_desc(3'd5, 7'h6F, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'd1, 32'h800);
            endcase
            req_valid = 1'b1;
            tick();
            vectors += 4;
            if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL imm_valid[%0d]: got %b expected 1", i, instr_valid); end
            if (instruction !== exp_w[i]) begin miscompares++; $display("FAIL imm_word[%0d]: got %h expected %h", i, instruction, exp_w[i]); end
            if (pc !== base + 64'(4 * i)) begin miscompares++; $display("FAIL imm_pc[%0d]: got %h expected %h", i, pc, base + 64'(4 * i)); end
            if (req_ready !== 1'b1) begin miscompares++; $display("FAIL imm_ready[%0d]: got %b expected 1", i, req_ready); end
        end
        req_valid = 1'b0;
        tick();
        instr_ready = 1'b0;
        vectors += 1;
        if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL imm_drained: got %b expected 0", instr_valid); end
    endtask

    task automatic test_backpressure();
        logic [32:0] ea, eb, ec;
        instr_ready = 1'b0; req_valid = 1'b1;
        rand_desc(5); ea = ref_encode(fmt, opcode, funct3, funct7, rs1, rs2, rd, imm);
        tick();
        rand_desc(5); eb = ref_encode(fmt, opcode, funct3, funct7, rs1, rs2, rd, imm);
        tick();
        vectors += 1;
        if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full: got ready %b expected 0", req_ready); end
        rand_desc(5); ec = ref_encode(fmt, opcode, funct3, funct7, rs1, rs2, rd, imm);
        tick();
        vectors += 2;
        if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_held: got ready %b expected 0", req_ready); end
        if (instruction !== ea[31:0]) begin miscompares++; $display("FAIL bp_head_a: got %h expected %h", instruction, ea[31:0]); end
        instr_ready = 1'b1;
        tick();
        vectors += 2;
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release: got ready %b expected 1", req_ready); end
        if (instruction !== eb[31:0]) begin miscompares++; $display("FAIL bp_head_b: got %h expected %h", instruction, eb[31:0]); end
        tick();
        req_valid = 1'b0;
        vectors += 2;
        if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid_c: got %b expected 1", instr_valid); end
        if (instruction !== ec[31:0]) begin miscompares++; $display("FAIL bp_head_c: got %h expected %h", instruction, ec[31:0]); end
        tick();
        instr_ready = 1'b0;
        vectors += 1;
        if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty: got %b expected 0", instr_valid); end
    endtask

    task automatic test_invalid();
        logic [63:0] pc0;
        logic [31:0] iss0;
        pc0 = m_pc; iss0 = m_iss;
        rand_desc(5);
        fmt = 3'(6 + $urandom_range(0, 1));
        req_valid = 1'b1; instr_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        vectors += 3;
        if (instruction !== 32'h0) begin miscompares++; $display("FAIL inv_word: got %h expected 0", instruction); end
        if (illegal !== 1'b1) begin miscompares++; $display("FAIL inv_illegal: got %b expected 1", illegal); end
        if (pc !== pc0) begin miscompares++; $display("FAIL inv_pc: got %h expected %h", pc, pc0); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        vectors += 2;
        if (pc !== pc0 + 64'd4) begin miscompares++; $display("FAIL inv_pc_step: got %h expected %h", pc, pc0 + 64'd4); end
        if (issued !== iss0 + 32'd1) begin miscompares++; $display("FAIL inv_issued: got %h expected %h", issued, iss0 + 32'd1); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rand_desc(7);
            req_valid   = ($urandom_range(0, 9) < 7);
            instr_ready = ($urandom_range(0, 9) < 6);
            tick();
            vectors += 4;
            if (instr_valid !== (mq.size() != 0)) begin miscompares++; $display("FAIL rnd_valid @%0d: got %b expected %b", c, instr_valid, mq.size() != 0); end
            if (req_ready !== (mq.size() < DEPTH)) begin miscompares++; $display("FAIL rnd_ready @%0d: got %b expected %b", c, req_ready, mq.size() < DEPTH); end
            if (pc !== m_pc) begin miscompares++; $display("FAIL rnd_pc @%0d: got %h expected %h", c, pc, m_pc); end
            if (issued !== m_iss) begin miscompares++; $display("FAIL rnd_issued @%0d: got %h expected %h", c, issued, m_iss); end
            if (mq.size() != 0) begin
                vectors += 1;
                if ({illegal, instruction} !== mq[0]) begin miscompares++; $display("FAIL rnd_head @%0d: got %b/%h expected %b/%h", c, illegal, instruction, mq[0][32], mq[0][31:0]); end
            end
        end
        req_valid = 1'b0; instr_ready = 1'b1;
        tick(); tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        instr_ready = 1'b1; req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_desc(5);
            if (i == 3) instr_ready = 1'b0;
            tick();
        end
        vectors += 2;
        if (pc !== BOOT + 64'd8) begin miscompares++; $display("FAIL mid_pre_pc: got %h expected %h", pc, BOOT + 64'd8); end
        if (req_ready !== 1'b0) begin miscompares++; $display("FAIL mid_pre_full: got %b expected 0", req_ready); end
        reset = 1'b1; instr_ready = 1'b1;
        tick();
        reset = 1'b0;
        vectors += 5;
        if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid: got %b expected 0", instr_valid); end
        if (pc !== BOOT) begin miscompares++; $display("FAIL mid_pc: got %h expected %h", pc, BOOT); end
        if (issued !== 32'd0) begin miscompares++; $display("FAIL mid_issued: got %h expected 0", issued); end
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL mid_ready: got %b expected 1", req_ready); end
        if (instruction !== 32'd0) begin miscompares++; $display("FAIL mid_instr: got %h expected 0", instruction); end
        req_valid = 1'b0;
        tick();
        instr_ready = 1'b0;
        vectors += 1;
        if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL mid_no_ghost: got %b expected 0", instr_valid); end
    endtask

    task automatic test_pc_wrap();
        w_req_valid = 1'b1; w_instr_ready = 1'b1;
        @(posedge clk); #1;
        vectors += 2;
        if (w_instr_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_valid0: got %b expected 1", w_instr_valid); end
        if (w_pc !== WBOOT) begin miscompares++; $display("FAIL wrap_pc0: got %h expected %h", w_pc, WBOOT); end
        @(posedge clk); #1;
        w_req_valid = 1'b0;
        vectors += 3;
        if (w_instr_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_valid1: got %b expected 1", w_instr_valid); end
        if (w_pc !== 64'd0) begin miscompares++; $display("FAIL wrap_pc1: got %h expected 0", w_pc); end
        if (w_instruction !== 32'h002081B3) begin miscompares++; $display("FAIL wrap_word: got %h expected 002081b3", w_instruction); end
        @(posedge clk); #1;
        w_instr_ready = 1'b0;
    endtask

    task automatic test_issued_wrap();
        do_reset();
        rand_desc(5);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        force dut.issued_q = 32'hFFFF_FFFF;
        #1;
        release dut.issued_q;
        m_iss = 32'hFFFF_FFFF;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        vectors += 2;
        if (issued !== 32'd0) begin miscompares++; $display("FAIL issued_wrap: got %h expected 0", issued); end
        if (issued !== m_iss) begin miscompares++; $display("FAIL issued_wrap_model: got %h expected %h", issued, m_iss); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        m_pc = BOOT; m_iss = 0;
        set_desc(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        reset = 1'b1; req_valid = 1'b0; instr_ready = 1'b0;
        w_req_valid = 1'b0; w_instr_ready = 1'b0;
        tick();
        test_reset();
        test_add();
        test_imm_formats();
        test_backpressure();
        test_invalid();
        test_random();
        test_reset_midstream();
        test_pc_wrap();
        test_issued_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
